// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the sequential shifter.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (arithmetic right shift).
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_one_step.sv
// Single shift-by-one stage. Left fills bit 0 with zero; right fills the
// top bit with the supplied fill bit (zero or the sign bit).
import shift_seq_pkg::*;

module shift_one_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic         dir,
    input  logic         fill,
    output logic [N-1:0] res
);

    // Shift the operand one position in the requested direction.
    always_comb begin
        res = {a[N-2:0], 1'b0};
        if (dir == DIR_RIGHT) begin
            res = {fill, a[N-1:1]};
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle variable-amount shifter: one bit position per clock.
// Optional feature macro: SHIFT_SEQ_ARITH_EN adds in_arith, which makes a
// right shift replicate the captured top bit instead of filling with zero.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_data is the registered working word, stable until out_ready.
// fsm_state exposes the controller state for observation only.
import shift_seq_pkg::*;

module shift_seq_unit #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amount,
    input  logic          in_dir,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic          in_arith,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output state_t        fsm_state
);

    state_t        state;
    state_t        next_state;
    logic [N-1:0]  work;
    logic [AW-1:0] count;
    logic          dir_q;
    logic          fill;
    logic [N-1:0]  step_res;
    logic          accept;

`ifdef SHIFT_SEQ_ARITH_EN
    logic          arith_q;

    // Sign fill only for right shifts requested as arithmetic.
    assign fill = (dir_q == DIR_RIGHT) && arith_q && work[N-1];
`else
    assign fill = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = work;
    assign fsm_state = state;

    shift_one_step #(.N(N)) u_step (
        .a    (work),
        .dir  (dir_q),
        .fill (fill),
        .res  (step_res)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: zero amount skips straight to DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (in_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count == AW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture the request at accept, then one step per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            work    <= '0;
            count   <= '0;
            dir_q   <= DIR_LEFT;
`ifdef SHIFT_SEQ_ARITH_EN
            arith_q <= 1'b0;
`endif
        end else if (accept) begin
            work    <= in_data;
            count   <= in_amount;
            dir_q   <= in_dir;
`ifdef SHIFT_SEQ_ARITH_EN
            arith_q <= in_arith;
`endif
        end else if (state == SHIFT) begin
            work  <= step_res;
            count <= count - AW'(1);
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed cases plus random
// operands against a reference built on the shift operators.
import shift_seq_pkg::*;

module tb_shift_seq_unit;

    localparam int N  = 8;
    localparam int AW = $clog2(N);
`ifdef SHIFT_SEQ_ARITH_EN
    localparam bit ARITH_EN = 1'b1;
`else
    localparam bit ARITH_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_amount;
    logic          in_dir;
`ifdef SHIFT_SEQ_ARITH_EN
    logic          in_arith;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    state_t        fsm_state;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    shift_seq_unit #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_dir    (in_dir),
`ifdef SHIFT_SEQ_ARITH_EN
        .in_arith  (in_arith),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fsm_state (fsm_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the shift operators themselves, truncated to N bits.
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int k,
                                               input logic dir, input logic ar);
        if (dir == 1'b0) return d << k;
        if (ar && ARITH_EN) return N'($signed(d) >>> k);
        return d >> k;
    endfunction

    // Present a request, wait for it to be accepted, then scramble inputs.
    task automatic drive_req(input logic [N-1:0] d, input logic [AW-1:0] k,
                             input logic dir, input logic ar);
        int w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("req_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = k;
        in_dir    = dir;
`ifdef SHIFT_SEQ_ARITH_EN
        in_arith  = ar;
`endif
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = N'($urandom);
        in_amount = AW'($urandom);
        in_dir    = 1'($urandom);
`ifdef SHIFT_SEQ_ARITH_EN
        in_arith  = 1'($urandom);
`endif
    endtask

    // Called in cycle T+1: checks latency, data, backpressure and release.
    task automatic expect_result(input int k, input int hold);
        int lat = 1;
        logic [N-1:0] exp;
        exp = exp_q.pop_front();
        while (!out_valid && lat < N + 5) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), 32'(k + 1));
        check("out_data", 32'(out_data), 32'(exp));
        check("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_state", 32'(fsm_state), 32'(IDLE));
    endtask

    task automatic run_op(input logic [N-1:0] d, input int k, input logic dir,
                          input logic ar, input int hold);
        exp_q.push_back(ref_shift(d, k, dir, ar));
        drive_req(d, AW'(k), dir, ar);
        expect_result(k, hold);
    endtask

    // Main sequence.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_dir    = 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
        in_arith  = 1'b0;
`endif
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_state", 32'(fsm_state), 32'(IDLE));

        // Directed cases.
        run_op(8'b1011_0111, 3, 1'b0, 1'b0, 0);
        run_op(8'hFF, 7, 1'b1, 1'b0, 0);
        run_op(8'hA5, 0, 1'b1, 1'b0, 0);
        run_op(8'h05, 2, 1'b0, 1'b0, 5);

        // Reset in the middle of a shift discards the operation.
        drive_req(8'h3C, AW'(6), 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 32'(fsm_state), 32'(IDLE));
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_data", 32'(out_data), 32'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_quiet", 32'(out_valid), 32'd0);
        end
        run_op(8'h01, 1, 1'b0, 1'b0, 0);

`ifdef SHIFT_SEQ_ARITH_EN
        run_op(8'b1000_0000, 3, 1'b1, 1'b1, 0);
        run_op(8'b1000_0000, 3, 1'b1, 1'b0, 0);
        run_op(8'b1000_0001, 2, 1'b0, 1'b1, 0);
`endif

        // Random operands with random backpressure.
        for (int n = 0; n < 200; n++) begin
            run_op(N'($urandom), $urandom_range(0, N - 1), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
